bcd_7seg_scan5: RTL

Downstream consumer of the 16-bit binary-to-BCD converter. It captures the five BCD digits when the converter pulses fin. It drives a 5-digit common-anode/cathode 7-segment display by time-multiplexing one digit at a time, with optional leading-zero blanking. Captured values are double-buffered so the displayed number only changes on a frame boundary, which prevents tearing.

---
 rtl/bcd_7seg_scan5.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bcd_7seg_scan5.sv
// Five-digit multiplexed 7-segment driver for the binary-to-BCD converter.
// A shadow register takes each converter result; the display copy only updates at frame wrap.
module bcd_7seg_scan5 #(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       fin,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [4:0] an,
  output logic       frame,
  output logic       pending
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [4:0]  AN_OFF   = AN_ACTIVE_LOW ? 5'h1F : 5'h00;

  logic [15:0] div_cnt;
  logic [2:0]  idx;
  logic [19:0] shadow;
  logic [19:0] disp;
  logic        blz_q;

  logic        tc;
  logic        wrap;
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic [6:0]  code;
  logic [4:0]  an_hot;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h40;
    endcase
    return c;
  endfunction

  // A digit is blanked only when it and every more-significant digit are zero,
  // so a dash (non-zero code) can never be blanked and digit 0 always shows.
  always_comb begin
    tc        = (div_cnt == DIV_LAST);
    wrap      = tc && (idx == 3'd4);
    cur_digit = 4'h0;
    cur_blank = 1'b0;
    an_hot    = 5'b00000;
    case (idx)
      3'd0: begin
        cur_digit = disp[3:0];
        an_hot    = 5'b00001;
      end
      3'd1: begin
        cur_digit = disp[7:4];
        cur_blank = blz_q && (disp[19:4] == 16'h0);
        an_hot    = 5'b00010;
      end
      3'd2: begin
        cur_digit = disp[11:8];
        cur_blank = blz_q && (disp[19:8] == 12'h0);
        an_hot    = 5'b00100;
      end
      3'd3: begin
        cur_digit = disp[15:12];
        cur_blank = blz_q && (disp[19:12] == 8'h0);
        an_hot    = 5'b01000;
      end
      3'd4: begin
        cur_digit = disp[19:16];
        cur_blank = blz_q && (disp[19:16] == 4'h0);
        an_hot    = 5'b10000;
      end
      default: ;
    endcase
    code = cur_blank ? 7'h00 : decode(cur_digit);
  end

  // fin is a one-cycle qualifier with no backpressure: bcd0..bcd4 are taken on
  // every cycle fin is high, and a later fin simply overwrites the shadow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      idx     <= '0;
      shadow  <= '0;
      disp    <= '0;
      blz_q   <= 1'b0;
      pending <= 1'b0;
      frame   <= 1'b0;
      seg     <= SEG_OFF;
      an      <= AN_OFF;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + 16'd1;
      if (tc) idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (wrap) begin
        blz_q <= blank_lz;
        if (pending) disp <= shadow;
      end
      // Capture after transfer: a fin on the wrap cycle stays pending for the next frame.
      if (fin) begin
        shadow  <= {bcd4, bcd3, bcd2, bcd1, bcd0};
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
      frame <= wrap;
      seg   <= code ^ {7{SEG_ACTIVE_LOW}};
      an    <= an_hot ^ {5{AN_ACTIVE_LOW}};
    end
  end

endmodule
